// File: rtl/pmem_burst_adapter_if.sv
// Line-side and burst-side signal bundle for the pmem burst adapter.
// slave is the adapter's view; master is the requester plus DRAM view.
interface pmem_burst_adapter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
);
    logic [31:0]           line_address;
    logic [LINE_WIDTH-1:0] line_wdata;
    logic                  line_read;
    logic                  line_write;
    logic [LINE_WIDTH-1:0] line_rdata;
    logic                  line_resp;
    logic [31:0]           burst_address;
    logic                  burst_read;
    logic                  burst_write;
    logic [BEAT_WIDTH-1:0] burst_wdata;
    logic [BEAT_WIDTH-1:0] burst_rdata;
    logic                  burst_resp;

    modport slave (
        input  line_address, line_wdata, line_read, line_write,
        input  burst_rdata, burst_resp,
        output line_rdata, line_resp,
        output burst_address, burst_read, burst_write, burst_wdata
    );

    modport master (
        output line_address, line_wdata, line_read, line_write,
        output burst_rdata, burst_resp,
        input  line_rdata, line_resp,
        input  burst_address, burst_read, burst_write, burst_wdata
    );
endinterface

// File: rtl/pmem_burst_adapter.sv
// Splits 256-bit cache-line reads/writes into 4 x 64-bit DRAM bursts
// and returns one line_resp pulse per completed line.
module pmem_burst_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pmem_burst_adapter_if.slave  bus
);
    localparam int CW = $clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFE0;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rbuf_q, rbuf_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  latch;
    logic                  burst_rd, burst_wr, resp;
    logic [BEAT_WIDTH-1:0] wbeat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            if (latch) begin
                addr_q  <= bus.line_address & ADDR_MASK;
                wdata_q <= bus.line_wdata;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rbuf_d   = rbuf_q;
        rdata_d  = rdata_q;
        latch    = 1'b0;
        burst_rd = 1'b0;
        burst_wr = 1'b0;
        resp     = 1'b0;
        wbeat    = '0;
        unique case (state_q)
            IDLE: begin
                // write has priority when both requests are raised
                if (bus.line_write) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                    latch   = 1'b1;
                end else if (bus.line_read) begin
                    state_d = READ;
                    cnt_d   = '0;
                    latch   = 1'b1;
                end
            end
            WRITE: begin
                burst_wr = 1'b1;
                wbeat    = wdata_q[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH];
                if (bus.burst_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST)
                        state_d = DONE;
                end
            end
            READ: begin
                burst_rd = 1'b1;
                if (bus.burst_resp) begin
                    rbuf_d[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] =
                        bus.burst_rdata;
                    cnt_d = cnt_q + 1'b1;
                    // publish the whole line together with the last beat
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        rdata_d = rbuf_d;
                    end
                end
            end
            DONE: begin
                resp    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.line_rdata    = rdata_q;
    assign bus.line_resp     = resp;
    assign bus.burst_address = addr_q;
    assign bus.burst_read    = burst_rd;
    assign bus.burst_write   = burst_wr;
    assign bus.burst_wdata   = wbeat;
endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Directed bench for pmem_burst_adapter: per-cycle expected outputs are
// built from each transaction's beat/stall plan and compared on negedge.
module tb_pmem_burst_adapter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmem_burst_adapter_if bus ();

    pmem_burst_adapter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int nchecks = 0;
    int nerrors = 0;
    int cyc = 0;
    int resp_cyc = 0;
    logic chk_en = 1'b0;

    logic [255:0] e_rdata = '0;
    logic         e_resp  = 1'b0;
    logic [31:0]  e_addr  = '0;
    logic         e_br    = 1'b0;
    logic         e_bw    = 1'b0;
    logic [63:0]  e_wdata = '0;

    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("line_rdata", bus.line_rdata, e_rdata);
            chk("line_resp", 256'(bus.line_resp), 256'(e_resp));
            chk("burst_address", 256'(bus.burst_address), 256'(e_addr));
            chk("burst_read", 256'(bus.burst_read), 256'(e_br));
            chk("burst_write", 256'(bus.burst_write), 256'(e_bw));
            chk("burst_wdata", 256'(bus.burst_wdata), 256'(e_wdata));
        end
    end

    task automatic set_exp(input logic br, input logic bw,
                           input logic [63:0] wd, input logic rs);
        e_br    = br;
        e_bw    = bw;
        e_wdata = wd;
        e_resp  = rs;
    endtask

    task automatic step();
        @(negedge clk);
        if (bus.line_resp === 1'b1 && resp_cyc == 0)
            resp_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
        bus.burst_resp = 1'b0;
        set_exp(1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < n; i++)
            step();
    endtask

    // One full line transaction; stall = idle cycles before every beat ack
    task automatic run_txn(input logic rd, input logic wr,
                           input logic [31:0] addr,
                           input logic [255:0] wd,
                           input logic [255:0] rb,
                           input int stall, input logic move_addr);
        logic iswr;
        logic [63:0] wb;
        iswr = wr;
        cyc = 1;
        resp_cyc = 0;
        bus.line_read    = rd;
        bus.line_write   = wr;
        bus.line_address = addr;
        bus.line_wdata   = wd;
        bus.burst_resp   = 1'b1;
        bus.burst_rdata  = JUNK;
        set_exp(1'b0, 1'b0, 64'h0, 1'b0);
        step();
        e_addr = {addr[31:5], 5'b0};
        if (move_addr)
            bus.line_address = 32'hFFFF_FFE0;
        for (int k = 0; k < 4; k++) begin
            wb = iswr ? wd[k*64 +: 64] : 64'h0;
            for (int s = 0; s < stall; s++) begin
                bus.burst_resp  = 1'b0;
                bus.burst_rdata = JUNK;
                set_exp(!iswr, iswr, wb, 1'b0);
                step();
            end
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = rb[k*64 +: 64];
            set_exp(!iswr, iswr, wb, 1'b0);
            step();
        end
        bus.burst_resp  = 1'b1;
        bus.burst_rdata = JUNK;
        set_exp(1'b0, 1'b0, 64'h0, 1'b1);
        if (!iswr)
            e_rdata = rb;
        step();
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
        bus.burst_resp = 1'b0;
        set_exp(1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    logic [255:0] rb1, wd1, wd2, rb2, rb3;

    initial begin
        rb1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        wd1 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        wd2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_1234_5678};
        rb2 = {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
               64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001};
        rb3 = {64'hCAFE_0000_0000_0040, 64'hCAFE_0000_0000_0030,
               64'hCAFE_0000_0000_0020, 64'hCAFE_0000_0000_0010};
        bus.line_read    = 1'b0;
        bus.line_write   = 1'b0;
        bus.line_address = '0;
        bus.line_wdata   = '0;
        bus.burst_rdata  = '0;
        bus.burst_resp   = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        run_txn(1'b1, 1'b0, 32'h0000_1234, '0, rb1, 0, 1'b0);
        chk("read_latency", 256'(resp_cyc), 256'd6);
        chk("read_line_lit", bus.line_rdata, rb1);
        chk("read_addr_lit", 256'(bus.burst_address), 256'(32'h0000_1220));
        idle(2);

        run_txn(1'b0, 1'b1, 32'h0000_0A00, wd1, '0, 2, 1'b0);
        chk("write_latency", 256'(resp_cyc), 256'd14);
        chk("write_keeps_rdata", bus.line_rdata, rb1);
        idle(1);

        run_txn(1'b1, 1'b1, 32'h0000_0B40, wd2, rb3, 0, 1'b0);
        chk("both_is_write", bus.line_rdata, rb1);
        idle(1);

        run_txn(1'b1, 1'b0, 32'h0000_0100, '0, rb2, 0, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0000_0200, wd2, '0, 1, 1'b0);
        chk("b2b_rdata_kept", bus.line_rdata, rb2);
        chk("b2b_addr_lit", 256'(bus.burst_address), 256'(32'h0000_0200));
        idle(1);

        run_txn(1'b1, 1'b0, 32'h0000_5678, '0, rb3, 1, 1'b1);
        chk("stable_addr_lit", 256'(bus.burst_address),
            256'(32'h0000_5660));
        chk("stable_rdata_lit", bus.line_rdata, rb3);
        idle(1);

        // write aborted by reset while beat 2 is on the bus
        cyc = 1;
        bus.line_write   = 1'b1;
        bus.line_address = 32'h0000_0C00;
        bus.line_wdata   = wd1;
        bus.burst_resp   = 1'b0;
        set_exp(1'b0, 1'b0, 64'h0, 1'b0);
        step();
        e_addr = 32'h0000_0C00;
        for (int k = 0; k < 2; k++) begin
            bus.burst_resp = 1'b1;
            set_exp(1'b0, 1'b1, wd1[k*64 +: 64], 1'b0);
            step();
        end
        bus.burst_resp = 1'b0;
        set_exp(1'b0, 1'b1, wd1[128 +: 64], 1'b0);
        #1;
        rst_n = 1'b0;
        e_rdata = '0;
        e_addr  = '0;
        set_exp(1'b0, 1'b0, 64'h0, 1'b0);
        #1;
        chk("rst_burst_write", 256'(bus.burst_write), 256'd0);
        chk("rst_burst_wdata", 256'(bus.burst_wdata), 256'd0);
        chk("rst_burst_addr", 256'(bus.burst_address), 256'd0);
        chk("rst_line_rdata", bus.line_rdata, 256'd0);
        bus.line_write = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);

        run_txn(1'b1, 1'b0, 32'h0000_0040, '0, rb2, 0, 1'b0);
        chk("recover_latency", 256'(resp_cyc), 256'd6);
        idle(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/pmem_burst_adapter.md
Name: pmem_burst_adapter

Overview:
- Sits directly downstream of the mp3 top level, on its physical-memory port (pmem_*).
- Converts each 256-bit cache-line read or write into a fixed burst of 64-bit beats on a narrow DRAM-style bus.
- Presents the single-response line handshake that mp3 expects: one line_resp pulse per completed line.
- Latches the request address and write data, sequences the beats, and assembles read beats into a full line.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BEAT_WIDTH, 64, burst bus data width in bits.
- BEATS, 4, beats per line; must equal LINE_WIDTH/BEAT_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- line_address  input  32  line request address (from mp3 pmem_address).
- line_wdata  input  256  line write data (from mp3 pmem_wdata).
- line_read  input  1  line read request, held until line_resp.
- line_write  input  1  line write request, held until line_resp.
- line_rdata  output  256  assembled read line; valid while line_resp=1.
- line_resp  output  1  one-cycle completion pulse.
- burst_address  output  32  line-aligned burst base address.
- burst_read  output  1  burst read active.
- burst_write  output  1  burst write active.
- burst_wdata  output  64  current write beat.
- burst_rdata  input  64  current read beat.
- burst_resp  input  1  beat accepted (write) / beat valid (read), one per beat.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, beat counter=0. All outputs 0: line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata.
- Reset asserted mid-burst: the burst is abandoned immediately, partial read data is discarded, and outputs take reset values in the same cycle.
- State IDLE: all burst controls low.
  - line_write=1 -> latch address and line_wdata, counter=0, go to WRITE.
  - else line_read=1 -> latch address, counter=0, go to READ.
  - line_read and line_write both 1: write wins; the read is ignored.
- Address latch: burst_address = {line_address[31:5], 5'b0}. It stays constant for the whole burst; later changes on line_address are ignored.
- State WRITE:
  - burst_write=1 and burst_wdata = latched_wdata[counter*64 +: 64]; beat 0 is bits 63:0, lowest beat first.
  - On burst_resp=1: counter increments. When counter==BEATS-1, go to DONE.
  - burst_resp=0: hold the current beat; there is no timeout.
- State READ:
  - burst_read=1.
  - On burst_resp=1: capture burst_rdata into line buffer slice [counter*64 +: 64] and increment counter. When counter==BEATS-1, go to DONE.
- State DONE:
  - line_resp=1 for exactly one cycle. line_rdata = assembled buffer (read) or holds its last value (write).
  - burst_read and burst_write are 0.
  - Next state is always IDLE.
- Counter: 2 bits wide (log2 BEATS); wraps to 0 on entry to WRITE or READ. Never observed outside 0..BEATS-1.
- Latency: with burst_resp asserted every cycle, request-to-line_resp is 1 (IDLE accept) + 4 (beats) + 1 (DONE) = 6 cycles. Each burst_resp stall cycle adds 1.
- Requester contract: line_read/line_write deassert in the cycle after line_resp. IDLE re-samples in that cycle, so a request still held there starts a new transaction. Back-to-back transactions are legal, with a minimum of one IDLE cycle between bursts.
- line_rdata holds its value between transactions until the next read's DONE. It is a registered output.
- burst_resp while in IDLE or DONE: ignored.

Test Plan:
- Reset: drive rst_n=0 mid-WRITE at beat 2 -> all outputs 0 in the same cycle. After release, state IDLE with no burst_write.
- Read, zero-wait: line_read=1, line_address=0x0000_1234. burst_resp=1 for beats 0x1111..1, 0x2222..2, 0x3333..3, 0x4444..4 -> burst_address=0x0000_1220, line_resp at cycle 6, line_rdata={4444..4, 3333..3, 2222..2, 1111..1}.
- Write with stalls: line_write=1, line_wdata=256'h{D,C,B,A beats}. burst_resp is low for 2 cycles before each beat -> burst_wdata sequence A,B,C,D, each held until acked. line_resp at cycle 14 (6 + 8 stall cycles), exactly one cycle wide.
- Simultaneous read and write in IDLE -> WRITE burst only; burst_read never asserted.
- Back-to-back: read 0x100 then write 0x200 with no gap from the requester -> second burst starts 1 cycle after the first line_resp with burst_address=0x200. The first line_rdata is unchanged by the write.
- Address stability: change line_address to 0xFFFF_FFE0 during READ -> burst_address stays at the latched value until DONE.
